// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage of the nic8 CPU: owns the program counter and instruction
// register, overlaps fetch with execute and inserts a fetch cycle after jumps/immediates.
module fetch_sequencer #(
    parameter int RETIRED_W = 16
) (
    input  logic                 clk,
    input  logic                 resetBar,
    input  logic [7:0]           romData,
    input  logic [7:0]           dbus,
    input  logic                 doJumpBar,
    input  logic                 assertRomBar,
    input  logic                 denyFetch,
    output logic [7:0]           pc,
    output logic [7:0]           ir,
    output logic [7:0]           instrAddr,
    output logic                 execute,
    output logic                 halted,
    output logic [RETIRED_W-1:0] retired
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } seqState;

    seqState              state;
    seqState              stateNext;
    logic [7:0]           pcNext;
    logic [7:0]           irNext;
    logic [7:0]           instrAddrNext;
    logic [RETIRED_W-1:0] retiredNext;

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state     <= FETCH;
            pc        <= 8'h00;
            ir        <= 8'h00;
            instrAddr <= 8'h00;
            retired   <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            ir        <= irNext;
            instrAddr <= instrAddrNext;
            retired   <= retiredNext;
        end
    end

    // Decoder inputs only matter in EXEC; the priority order below picks the next PC.
    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        irNext        = ir;
        instrAddrNext = instrAddr;
        retiredNext   = retired;
        case (state)
            FETCH: begin
                irNext        = romData;
                instrAddrNext = pc;
                pcNext        = pc + 8'd1;
                stateNext     = EXEC;
            end
            EXEC: begin
                retiredNext = retired + RETIRED_W'(1);
                if (!doJumpBar && (dbus == instrAddr)) begin
                    stateNext = HALT;
                end else if (!doJumpBar) begin
                    pcNext    = dbus;
                    stateNext = FETCH;
                end else if (!assertRomBar) begin
                    pcNext    = pc + 8'd1;
                    stateNext = FETCH;
                end else if (!denyFetch) begin
                    irNext        = romData;
                    instrAddrNext = pc;
                    pcNext        = pc + 8'd1;
                end else begin
                    // Inconsistent decoder request: consume the byte but refetch next cycle.
                    pcNext    = pc + 8'd1;
                    stateNext = FETCH;
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    assign execute = (state == EXEC);
    assign halted  = (state == HALT);

endmodule
